snake_matrix_scan: RTL and testbench
====================================

Name: snake_matrix_scan

Overview:
- Display-side consumer of the snake game state: takes the packed 4-segment snake body, snake length, food position and move strobe, and renders them into a 64-bit bitmap.
- Drives an 8x8 LED matrix by row multiplexing.
- Sits between the snake game logic and the board LED matrix pins.
- Double-buffered: a new frame is swapped in only at a row-0 boundary, so the display never tears.

Parameters:
- SCAN_DIV, 25000: sys_clk cycles per row slot (50 MHz gives 2 kHz rows, 250 Hz frames).
- BLINK_FRAMES, 32: frames per food/win blink half-period.
- BLANK_CYC, 16: blanking cycles after each row change; used only with SCAN_GHOST_BLANK_EN.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- snake_body  in  24  segment k position at [23-6k -: 6], k=0 is head; pixel p: row=p[5:3], col=p[2:0].
- snake_len  in  3  live segments, legal 1..4.
- score_position  in  6  food pixel index.
- move  in  1  single-cycle frame-update strobe.
- win  in  1  level; game won.
- row_sel  out  8  active-low one-hot row drive.
- col_data  out  8  active-high column data; bit c = pixel row*8+c.
- busy  out  1  render or swap pending.
- frame_sync  out  1  one-cycle pulse when scan enters row 0.

Behaviour:
- Interface (already decided): one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values:
  - row_sel=8'hFF; col_data=0; busy=0; frame_sync=0.
  - Prescaler=0; row_idx=7, so the first tick selects row 0.
  - Work and display buffers=0; food_on=0; frame counter=0; FSM=IDLE.
- Reset mid-render discards the snapshot and work buffer.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick when count==SCAN_DIV-1, then wraps to 0.
  - On tick, registered: row_idx<=row_idx+1 (mod 8); row_sel<=~(8'b1<<next); col_data<=row data of next.
  - frame_sync=1 for the same cycle that row_sel first shows row 0.
  - First row drive appears SCAN_DIV cycles after reset release.
- Row data:
  - Normal: disp_buf row bits, OR food bit if food_on and disp_food falls in that row.
  - Food on a body pixel: the pixel stays lit (OR).
  - win=1: col_data=8'hFF when food_on, else 8'h00; scanning continues and disp_buf is ignored.
- Blink: frame counter increments per frame_sync; at BLINK_FRAMES-1 it wraps and food_on toggles.
- Render FSM (states IDLE, CLEAR, PLOT, WAIT_SWAP):
  - IDLE: on move, latch snake_body, snake_len and score_position into the snapshot; go to CLEAR.
  - Length clamp: len=0 becomes 1; len>4 becomes 4.
  - CLEAR (1 cycle): work_buf<=0; seg<=0.
  - PLOT: one segment per cycle, work_buf[pos_seg]<=1, seg++. After seg==len-1, work_food<=snapshot food, go to WAIT_SWAP.
  - WAIT_SWAP: on the tick whose next row is 0, disp_buf<=work_buf and disp_food<=work_food in that same cycle, so row 0 shows the new frame; go to IDLE.
  - busy=1 in every state except IDLE.
  - move while busy: re-latch the snapshot and restart at CLEAR (newest wins); disp_buf untouched.
  - move on the swap cycle: the swap completes, then the FSM enters CLEAR with the new snapshot.
- Duplicate segment positions (e.g. all 15 after game reset) OR into one lit pixel.
- Render latency: move to WAIT_SWAP is 2+len cycles; the swap lands at most 8*SCAN_DIV cycles later.

Optional Feature:
- SCAN_GHOST_BLANK_EN defined:
  - After each tick, col_data is forced to 8'h00 for BLANK_CYC cycles, then row data is driven; row_sel changes at the tick as normal.
  - Requires BLANK_CYC < SCAN_DIV.
- SCAN_GHOST_BLANK_EN undefined: col_data is valid in the same cycle as row_sel; BLANK_CYC is unused.

Test Plan:
- SCAN_DIV=4, reset, idle 40 cycles:
  - row_sel steps FE,FD,FB..7F,FE every 4 cycles; col_data=0.
  - frame_sync pulses with each row_sel=FE.
- move with body={15,15,15,15}, len=1, food=0, BLINK_FRAMES=1:
  - busy rises next cycle.
  - After the next row-0 swap: row 1 col_data=8'h80, and row 0=8'h01 only on alternating frames.
- move with body={9,10,11,12}, len=4, food=12:
  - Row 1 col_data=8'h1E, steady across blink phases (food overlaps body).
- Second move, 2 cycles after the first (during PLOT):
  - Displayed frame reflects the second snapshot only; no intermediate frame shown.
- win=1, BLINK_FRAMES=2:
  - All rows 8'hFF for 2 frames, then 8'h00 for 2 frames, repeating.
- sys_rst asserted in WAIT_SWAP:
  - Next cycle: busy=0, row_sel=FF, col_data=0; display stays blank until a new move.

Source files
------------

// File: rtl/snake_matrix_scan.sv
// Renders the snake body and food into a double-buffered 8x8 bitmap and row-multiplexes it
// onto an LED matrix. Optional ghost blanking is enabled by defining SCAN_GHOST_BLANK_EN.
module snake_matrix_scan #(
    parameter int unsigned SCAN_DIV     = 25000,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned BLANK_CYC    = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [23:0] snake_body,
    input  logic [2:0]  snake_len,
    input  logic [5:0]  score_position,
    input  logic        move,
    input  logic        win,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        busy,
    output logic        frame_sync
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StClear, StPlot, StWaitSwap} state_e;

    // Scan side
    logic [PW-1:0] presc_q;
    logic [2:0]    row_idx_q;
    logic [2:0]    row_next;
    logic          tick;
    logic          frame_tick;
    logic [7:0]    row_sel_q;
    logic [7:0]    row_data_q;
    logic [7:0]    row_data_d;
    logic          frame_sync_q;
    logic [FW-1:0] frame_cnt_q;
    logic [FW-1:0] frame_cnt_d;
    logic          food_on_q;
    logic          food_on_d;

    // Render side
    state_e        state_q;
    state_e        state_d;
    logic [23:0]   snap_body_q;
    logic [1:0]    snap_last_q;
    logic [5:0]    snap_food_q;
    logic [1:0]    len_last;
    logic [1:0]    seg_q;
    logic [5:0]    plot_pos;
    logic          plot_last;
    logic [63:0]   work_buf_q;
    logic [5:0]    work_food_q;
    logic [63:0]   disp_buf_q;
    logic [5:0]    disp_food_q;
    logic          disp_valid_q;
    logic          swap;

    // Row data source for the next slot
    logic [63:0]   src_buf;
    logic [5:0]    src_food;
    logic          src_valid;
    logic [7:0]    food_bits;

    assign tick       = (presc_q == PRESC_MAX);
    assign row_next   = row_idx_q + 3'd1;
    assign frame_tick = tick && (row_next == 3'd0);
    assign swap       = (state_q == StWaitSwap) && frame_tick;
    assign plot_last  = (seg_q == snap_last_q);

    // Blink state advances on the edge that enters row 0, so a whole frame shares one phase.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        food_on_d   = food_on_q;
        if (frame_tick) begin
            if (frame_cnt_q == FRAME_MAX) begin
                frame_cnt_d = '0;
                food_on_d   = ~food_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // On the swap edge row 0 is built straight from the work buffer.
    always_comb begin
        src_buf   = swap ? work_buf_q  : disp_buf_q;
        src_food  = swap ? work_food_q : disp_food_q;
        src_valid = swap | disp_valid_q;
        food_bits = 8'h00;
        if (food_on_d && src_valid && (src_food[5:3] == row_next)) begin
            food_bits[src_food[2:0]] = 1'b1;
        end
        if (win) begin
            row_data_d = {8{food_on_d}};
        end else begin
            row_data_d = src_buf[{row_next, 3'b000} +: 8] | food_bits;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q      <= '0;
            row_idx_q    <= 3'd7;
            row_sel_q    <= 8'hFF;
            row_data_q   <= 8'h00;
            frame_sync_q <= 1'b0;
            frame_cnt_q  <= '0;
            food_on_q    <= 1'b0;
        end else begin
            presc_q      <= tick ? '0 : presc_q + PW'(1);
            frame_sync_q <= frame_tick;
            frame_cnt_q  <= frame_cnt_d;
            food_on_q    <= food_on_d;
            if (tick) begin
                row_idx_q  <= row_next;
                row_sel_q  <= ~(8'b1 << row_next);
                row_data_q <= row_data_d;
            end
        end
    end

    assign row_sel    = row_sel_q;
    assign frame_sync = frame_sync_q;

`ifdef SCAN_GHOST_BLANK_EN
    localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [BW-1:0] blank_cnt_q;

    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("BLANK_CYC must be smaller than SCAN_DIV");
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blank_cnt_q <= '0;
        end else if (tick) begin
            blank_cnt_q <= BW'(BLANK_CYC);
        end else if (blank_cnt_q != '0) begin
            blank_cnt_q <= blank_cnt_q - BW'(1);
        end
    end

    assign col_data = (blank_cnt_q != '0) ? 8'h00 : row_data_q;
`else
    assign col_data = row_data_q;
`endif

    // Length clamp: 0 plots one segment, anything above 4 plots four.
    always_comb begin
        unique case (snake_len)
            3'd0, 3'd1: len_last = 2'd0;
            3'd2:       len_last = 2'd1;
            3'd3:       len_last = 2'd2;
            default:    len_last = 2'd3;
        endcase
    end

    always_comb begin
        unique case (seg_q)
            2'd0:    plot_pos = snap_body_q[23:18];
            2'd1:    plot_pos = snap_body_q[17:12];
            2'd2:    plot_pos = snap_body_q[11:6];
            default: plot_pos = snap_body_q[5:0];
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     state_d = StIdle;
            StClear:    state_d = StPlot;
            StPlot:     if (plot_last) state_d = StWaitSwap;
            StWaitSwap: if (swap) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Newest snapshot wins; a swap on this same edge still completes.
        if (move) begin
            state_d = StClear;
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            snap_body_q  <= '0;
            snap_last_q  <= '0;
            snap_food_q  <= '0;
            seg_q        <= '0;
            work_buf_q   <= '0;
            work_food_q  <= '0;
            disp_buf_q   <= '0;
            disp_food_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            if (move) begin
                snap_body_q <= snake_body;
                snap_last_q <= len_last;
                snap_food_q <= score_position;
            end
            if (state_q == StClear) begin
                work_buf_q <= '0;
                seg_q      <= '0;
            end
            if (state_q == StPlot) begin
                work_buf_q[plot_pos] <= 1'b1;
                seg_q                <= seg_q + 2'd1;
                if (plot_last) begin
                    work_food_q <= snap_food_q;
                end
            end
            if (swap) begin
                disp_buf_q   <= work_buf_q;
                disp_food_q  <= work_food_q;
                disp_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Scoreboard bench for snake_matrix_scan: two instances (blink 1 and 2 frames) share stimulus;
// queued frames are promoted at their predicted row-0 swap edge and every scan cycle is compared.
module tb_snake_matrix_scan;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [23:0] snake_body = '0;
    logic [2:0]  snake_len = 3'd1;
    logic [5:0]  score_position = '0;
    logic        move = 1'b0;
    logic        win = 1'b0;

    logic [7:0] row_sel_a, col_data_a, row_sel_b, col_data_b;
    logic       busy_a, busy_b, fs_a, fs_b;

    snake_matrix_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .snake_body(snake_body), .snake_len(snake_len),
        .score_position(score_position), .move(move), .win(win), .row_sel(row_sel_a),
        .col_data(col_data_a), .busy(busy_a), .frame_sync(fs_a)
    );

    snake_matrix_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(2)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .snake_body(snake_body), .snake_len(snake_len),
        .score_position(score_position), .move(move), .win(win), .row_sel(row_sel_b),
        .col_data(col_data_b), .busy(busy_b), .frame_sync(fs_b)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] pix;
        logic [5:0]  food;
        int          swap_at;
    } frame_t;

    frame_t      pending[$];
    logic [63:0] cur_pix = '0;
    logic [5:0]  cur_food = '0;
    logic        cur_valid = 1'b0;
    int          cyc = 0;
    int          frames = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_row_sel = 8'hFF;
    logic [7:0]  exp_col_a = 8'h00;
    logic [7:0]  exp_col_b = 8'h00;
    logic        exp_fs = 1'b0;

    // Cycles since reset release, counted by the bench itself.
    always @(posedge sys_clk) cyc <= sys_rst ? 0 : cyc + 1;

    function automatic logic [7:0] model_col(input int r, input logic food_on);
        logic [7:0] v;
        if (win) return food_on ? 8'hFF : 8'h00;
        if (!cur_valid) return 8'h00;
        v = cur_pix[r*8 +: 8];
        if (food_on && int'(cur_food[5:3]) == r) v[cur_food[2:0]] = 1'b1;
        return v;
    endfunction

    always @(posedge sys_clk) begin
        int     r;
        frame_t fr;
        #1;
        if (sys_rst) begin
            pending.delete();
            cur_valid   = 1'b0;
            cur_pix     = '0;
            cur_food    = '0;
            frames      = 0;
            exp_row_sel = 8'hFF;
            exp_col_a   = 8'h00;
            exp_col_b   = 8'h00;
            exp_fs      = 1'b0;
        end else begin
            exp_fs = 1'b0;
            if (cyc >= SD && cyc % SD == 0) begin
                r = (cyc / SD - 1) % 8;
                if (r == 0) begin
                    frames++;
                    exp_fs = 1'b1;
                    if (pending.size() > 0 && pending[0].swap_at == cyc) begin
                        fr        = pending.pop_front();
                        cur_pix   = fr.pix;
                        cur_food  = fr.food;
                        cur_valid = 1'b1;
                    end
                end
                exp_row_sel = ~(8'b1 << r);
                exp_col_a   = model_col(r, (frames % 2) == 1);
                exp_col_b   = model_col(r, ((frames / 2) % 2) == 1);
            end
            checks += 6;
            if (row_sel_a !== exp_row_sel) begin
                failures++;
                $display("FAIL scan_row_sel_a cyc=%0d got=%h exp=%h", cyc, row_sel_a, exp_row_sel);
            end
            if (row_sel_b !== exp_row_sel) begin
                failures++;
                $display("FAIL scan_row_sel_b cyc=%0d got=%h exp=%h", cyc, row_sel_b, exp_row_sel);
            end
            if (col_data_a !== exp_col_a) begin
                failures++;
                $display("FAIL scan_col_a cyc=%0d got=%h exp=%h", cyc, col_data_a, exp_col_a);
            end
            if (col_data_b !== exp_col_b) begin
                failures++;
                $display("FAIL scan_col_b cyc=%0d got=%h exp=%h", cyc, col_data_b, exp_col_b);
            end
            if (fs_a !== exp_fs) begin
                failures++;
                $display("FAIL frame_sync_a cyc=%0d got=%b exp=%b", cyc, fs_a, exp_fs);
            end
            if (fs_b !== exp_fs) begin
                failures++;
                $display("FAIL frame_sync_b cyc=%0d got=%b exp=%b", cyc, fs_b, exp_fs);
            end
        end
    end

    // Called at a negedge; the move is sampled on the next posedge and its frame is queued.
    task automatic do_move(input logic [5:0] b0, input logic [5:0] b1, input logic [5:0] b2,
                           input logic [5:0] b3, input logic [2:0] len, input logic [5:0] food,
                           output int swap_at);
        frame_t     fr;
        logic [5:0] b[4];
        int         c;
        int         n;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        c = cyc + 1;
        n = (len == 3'd0) ? 1 : ((len > 3'd4) ? 4 : int'(len));
        fr.pix = '0;
        for (int k = 0; k < n; k++) fr.pix[b[k]] = 1'b1;
        fr.food = food;
        fr.swap_at = c + 2 + n;
        while (fr.swap_at % FRAME != SD) fr.swap_at++;
        if (pending.size() > 0 && pending[$].swap_at > c) void'(pending.pop_back());
        pending.push_back(fr);
        swap_at = fr.swap_at;
        snake_body = {b0, b1, b2, b3};
        snake_len = len;
        score_position = food;
        move = 1'b1;
        @(negedge sys_clk);
        move = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        if (cyc != target) begin
            failures++;
            $display("FAIL wait_cyc got=%0d exp=%0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        checks += 4;
        if (row_sel_a !== 8'hFF || row_sel_b !== 8'hFF) begin
            failures++;
            $display("FAIL reset_row_sel got=%h/%h exp=ff", row_sel_a, row_sel_b);
        end
        if (col_data_a !== 8'h00 || col_data_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_col got=%h/%h exp=00", col_data_a, col_data_b);
        end
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b/%b exp=0", busy_a, busy_b);
        end
        if (fs_a !== 1'b0 || fs_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_sync got=%b/%b exp=0", fs_a, fs_b);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (40) @(negedge sys_clk);
    endtask

    task automatic run_frame(input logic [5:0] b0, input logic [5:0] b1, input logic [5:0] b2,
                             input logic [5:0] b3, input logic [2:0] len, input logic [5:0] food,
                             input int hold_frames, input string name);
        int sw;
        do_move(b0, b1, b2, b3, len, food, sw);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_rise got=%b/%b exp=1", name, busy_a, busy_b);
        end
        wait_cyc(sw);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_fall got=%b/%b exp=0", name, busy_a, busy_b);
        end
        repeat (hold_frames * FRAME) @(negedge sys_clk);
    endtask

    task automatic test_single_segment();
        run_frame(6'd15, 6'd15, 6'd15, 6'd15, 3'd1, 6'd0, 4, "single");
    endtask

    task automatic test_food_overlap();
        run_frame(6'd9, 6'd10, 6'd11, 6'd12, 3'd4, 6'd12, 4, "overlap");
    endtask

    task automatic test_len_clamp();
        run_frame(6'd20, 6'd21, 6'd22, 6'd23, 3'd0, 6'd40, 2, "clamp_lo");
        run_frame(6'd33, 6'd34, 6'd35, 6'd36, 3'd6, 6'd1, 2, "clamp_hi");
    endtask

    task automatic test_back_to_back();
        int sw;
        do_move(6'd0, 6'd1, 6'd2, 6'd3, 3'd4, 6'd63, sw);
        @(negedge sys_clk);
        do_move(6'd56, 6'd57, 6'd58, 6'd59, 3'd3, 6'd7, sw);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy got=%b/%b exp=1", busy_a, busy_b);
        end
        wait_cyc(sw);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_fall got=%b/%b exp=0", busy_a, busy_b);
        end
        repeat (3 * FRAME) @(negedge sys_clk);
    endtask

    task automatic test_win();
        win = 1'b1;
        repeat (8 * FRAME) @(negedge sys_clk);
        win = 1'b0;
        repeat (2 * FRAME) @(negedge sys_clk);
    endtask

    task automatic test_reset_wait_swap();
        int sw;
        int guard = 0;
        while (cyc % FRAME != SD + 1 && guard < 2 * FRAME) begin
            @(negedge sys_clk);
            guard++;
        end
        do_move(6'd40, 6'd41, 6'd42, 6'd43, 3'd4, 6'd5, sw);
        repeat (8) @(negedge sys_clk);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL wait_swap_busy got=%b/%b exp=1", busy_a, busy_b);
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        checks += 3;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_swap_busy got=%b/%b exp=0", busy_a, busy_b);
        end
        if (row_sel_a !== 8'hFF || row_sel_b !== 8'hFF) begin
            failures++;
            $display("FAIL rst_swap_row_sel got=%h/%h exp=ff", row_sel_a, row_sel_b);
        end
        if (col_data_a !== 8'h00 || col_data_b !== 8'h00) begin
            failures++;
            $display("FAIL rst_swap_col got=%h/%h exp=00", col_data_a, col_data_b);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3 * FRAME) @(negedge sys_clk);
        run_frame(6'd7, 6'd7, 6'd7, 6'd7, 3'd2, 6'd62, 2, "recover");
    endtask

    initial begin
        test_reset();
        test_single_segment();
        test_food_overlap();
        test_len_clamp();
        test_back_to_back();
        test_win();
        test_reset_wait_swap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
